dma_stream_ctrl: RTL and testbench
==================================

# dma_stream_ctrl

Parametrised host-side DMA controller for the tensorcore scratchpad. It moves data between the input/output streams and the scratchpad's DMA port:
- On writes, it unpacks wide input beats into scratchpad words.
- On reads, it streams scratchpad words out through a 2-entry buffer, sustaining one word per cycle under backpressure.
- It runs only while the compute FSM is idle, and reports busy/done/err to the top-level control FSM.

## Interface
Parameters:
- ADDR_W, 13, scratchpad word-address width
- DATA_W, 32, scratchpad word width
- IN_W, 64, input stream width; must be an integer multiple of DATA_W; LANES = IN_W/DATA_W
- LEN_W, 16, transfer-length width in words

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  1 = WRITE (stream to memory), 2 = READ (memory to stream); 0 and 3 are illegal
- cmd_addr  in  ADDR_W  base word address
- cmd_len  in  LEN_W  transfer length in words; 0 is illegal
- abort  in  1  cancels the active transfer
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a transfer completes
- err  out  1  sticky; set by an illegal command, cleared by the next accepted legal command
- din_valid / din_ready  in / out  1 / 1  input stream handshake
- din_data  in  IN_W  input beat; lane 0 is in the low DATA_W bits
- dout_valid / dout_ready  out / in  1 / 1  output stream handshake
- dout_data  out  DATA_W  output word
- mem_en, mem_we  out  1, 1  scratchpad port enable and write enable
- mem_addr  out  ADDR_W  scratchpad address
- mem_wdata  out  DATA_W  scratchpad write data
- mem_rdata  in  DATA_W  scratchpad read data, valid 1 cycle after a read with mem_en=1, mem_we=0

## Operation
**States:** IDLE, WRITE, READ, DONE.

**IDLE**
- A command is accepted when cmd_valid && cmd_ready. The block latches addr, len and op, and clears ptr.
- A legal op moves to WRITE or READ.
- An illegal op or len=0 sets err and stays in IDLE. No done pulse is generated.

**WRITE**
- A hold register stores the beat plus a lane index.
- din_ready = hold empty, or lane == LANES-1 while more words remain beyond the current beat.
- Each cycle the hold register is non-empty, the block writes one lane: mem_addr = addr+ptr, then ptr++.
- On the final beat, lanes beyond len are discarded.
- When ptr reaches len, the state moves to DONE.

**READ**
- The block issues a read (mem_addr = addr+ptr) when the count of FIFO entries plus in-flight reads is below 2 and ptr < len, then increments ptr.
- Returned data is pushed into the FIFO on the next cycle.
- dout_valid = FIFO not empty.
- When the last word is popped, the state moves to DONE.

**DONE**
- done=1 for one cycle, then the state returns to IDLE.

**Addressing:** addr+ptr wraps modulo 2^ADDR_W; no error is raised.

**Abort (any non-IDLE state):**
- The next state is IDLE.
- The hold register and FIFO are flushed. In-flight read data is dropped.
- No done pulse; err is unchanged.
- Writes already performed remain in memory.

## Timing
- Reset values: all outputs 0, except cmd_ready=1. State = IDLE; FIFO and hold register empty.
- Command accepted at cycle C:
  - WRITE: din_ready rises at C+1.
  - READ: first mem read at C+1; first dout_valid at C+2.
- WRITE: a beat accepted at cycle N produces writes at N+1 .. N+LANES. With din held valid, the block sustains 1 word/cycle.
- READ: with dout_ready held high, the block sustains 1 word/cycle. With dout_ready low, at most 2 words are buffered and no read is issued.
- done pulses on the cycle after the last write, or on the cycle after the last dout handshake.
- abort and the final transfer in the same cycle: abort wins, so no done.
- abort in IDLE or DONE: ignored.

## Configuration
- DMA_STALL_CNT_EN defined: adds output port stall_cnt (32 bits).
  - Counts cycles in WRITE or READ with no memory access and no dout handshake.
  - Cleared on command accept; saturates at all-ones.
  - Reset value 0.
- DMA_STALL_CNT_EN not defined: the port and its logic are absent. Behaviour is otherwise identical.

## Structure
- Package dma_pkg holds:
  - dma_op_e: OP_NOP=0, OP_WRITE=1, OP_READ=2, OP_RSVD=3
  - dma_state_e
  - FIFO depth localparam (2)
- Sub-module dma_out_fifo: 2-entry synchronous FIFO (DATA_W) with flush input, full/empty outputs and a valid/ready pop port.

## Test plan
- WRITE: addr=0x10, len=5, LANES=2, beats {0x2_1, 0x4_3, 0x6_5} -> memory 0x10..0x14 = 1..5; upper lane of beat 3 discarded; exactly 3 din handshakes; one done pulse.
- READ: addr=0x1FFE, len=4, memory preloaded with incrementing data -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001 read in order; dout matches; done pulse.
- READ backpressure: len=8, dout_ready toggles 1,0,0,1 -> no word lost or duplicated; never more than 2 buffered words.
- Illegal commands: op=3 and, separately, len=0 -> err=1, no done, busy stays 0. A following legal WRITE clears err.
- Abort: abort asserted during a READ after 3 words -> IDLE next cycle; dout_valid=0; no done. A new command is accepted immediately.
- Reset mid-WRITE: rst_n low -> all outputs at reset values asynchronously; stall_cnt=0 when DMA_STALL_CNT_EN is defined.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the scratchpad DMA stream controller.
package dma_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_RSVD  = 2'd3
  } dma_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DONE
  } dma_state_e;

  // Entries in the read-return buffer; also the cap on buffered plus in-flight reads.
  localparam int FIFO_DEPTH = 2;

  function automatic logic op_is_legal(input logic [1:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/dma_out_fifo.sv
// Two-entry read-return buffer with fall-through: a word pushed into an
// empty buffer is visible on the pop side in the same cycle.
module dma_out_fifo
  import dma_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              store;
  logic              deq;

  assign empty     = (count == 2'd0);
  assign full      = (count == 2'(FIFO_DEPTH));
  assign pop_valid = !empty || push;
  // A push into an empty buffer that is popped at once bypasses storage.
  assign store     = push && !(empty && pop_ready);
  assign deq       = !empty && pop_ready;
  assign pop_data  = !empty ? mem[rd_ptr] : (push ? push_data : '0);

  // Pointer and occupancy bookkeeping; flush empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (store) wr_ptr <= ~wr_ptr;
      if (deq)   rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, store} - {1'b0, deq};
    end
  end

  // NOTE: storage has no reset; occupancy alone decides what is valid, so
  // the data flops can stay plain registers.
  // Capture pushed words into the slot named by the write pointer.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dma_stream_ctrl.sv
// Host-side DMA controller between the stream ports and the scratchpad DMA
// port. Optional build macro DMA_STALL_CNT_EN adds a 32-bit stall_cnt output
// counting active cycles without a memory access or output handshake.
module dma_stream_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int IN_W   = 64,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [IN_W-1:0]   din_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
`ifdef DMA_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LANES  = IN_W / DATA_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  dma_state_e        state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  ptr;
  logic [LEN_W-1:0]  ptr_next;
  logic [IN_W-1:0]   hold_data;
  logic              hold_valid;
  logic [LANE_W-1:0] lane;
  logic              rd_pend;
  logic              err_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        outstanding;
  logic              last_lane;
  logic              wr_en;
  logic              rd_en;
  logic              din_hs;
  logic              dout_hs;
  logic              rd_last;
  logic              cmd_legal;
  logic              flush;
  logic [ADDR_W-1:0] cur_addr;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign err       = err_q;

  assign cmd_legal = op_is_legal(cmd_op) && (cmd_len != '0);
  assign ptr_next  = ptr + LEN_W'(1);
  // Address arithmetic wraps silently at the top of the scratchpad.
  assign cur_addr  = addr + ADDR_W'(ptr);

  // Write side: one lane of the held beat goes out per cycle.
  assign last_lane = (lane == LANE_W'(LANES - 1));
  assign wr_en     = (state == ST_WRITE) && hold_valid;
  assign din_ready = (state == ST_WRITE) &&
                     (!hold_valid || (last_lane && (ptr_next < len)));
  assign din_hs    = din_valid && din_ready;

  // Read side: buffered plus in-flight words never exceed the buffer depth.
  assign outstanding = (fifo_full ? 2'd2 : {1'b0, !fifo_empty}) + {1'b0, rd_pend};
  assign rd_en       = (state == ST_READ) && (ptr < len) &&
                       (outstanding < 2'(FIFO_DEPTH));
  assign dout_hs     = dout_valid && dout_ready;
  assign rd_last     = (state == ST_READ) && dout_hs && (ptr == len) &&
                       (outstanding == 2'd1);

  assign mem_en    = wr_en || rd_en;
  assign mem_we    = wr_en;
  assign mem_addr  = mem_en ? cur_addr : '0;
  assign mem_wdata = wr_en ? hold_data[lane*DATA_W +: DATA_W] : '0;

  assign flush = abort && ((state == ST_WRITE) || (state == ST_READ));

  dma_out_fifo #(
    .DATA_W (DATA_W)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (rd_pend),
    .push_data (mem_rdata),
    .pop_valid (dout_valid),
    .pop_ready (dout_ready),
    .pop_data  (dout_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Transfer FSM: command capture, beat unpacking, read issue and abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr       <= '0;
      len        <= '0;
      ptr        <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      lane       <= '0;
      rd_pend    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: every state update is non-blocking so all branches see the
      // pre-edge values of ptr, lane and hold_valid.
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr <= cmd_addr;
            len  <= cmd_len;
            ptr  <= '0;
            if (cmd_legal) begin
              err_q <= 1'b0;
              state <= (cmd_op == OP_WRITE) ? ST_WRITE : ST_READ;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (abort) begin
            state      <= ST_IDLE;
            hold_valid <= 1'b0;
          end else begin
            if (wr_en) begin
              ptr  <= ptr_next;
              lane <= lane + LANE_W'(1);
              if (ptr_next == len) state <= ST_DONE;
            end
            if (din_hs) begin
              hold_data  <= din_data;
              hold_valid <= 1'b1;
              lane       <= '0;
            end else if (wr_en && (last_lane || (ptr_next == len))) begin
              // Beat exhausted, or the transfer ends mid-beat and the
              // remaining lanes are dropped.
              hold_valid <= 1'b0;
            end
          end
        end
        ST_READ: begin
          if (abort) begin
            state   <= ST_IDLE;
            rd_pend <= 1'b0;
          end else begin
            rd_pend <= rd_en;
            if (rd_en)   ptr   <= ptr_next;
            if (rd_last) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMA_STALL_CNT_EN
  // Saturating count of active cycles that move no data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cmd_valid && cmd_ready) begin
      stall_cnt <= '0;
    end else if (((state == ST_WRITE) || (state == ST_READ)) &&
                 !mem_en && !dout_hs && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_stream_ctrl.sv
// Directed bench for dma_stream_ctrl with a behavioural scratchpad model.
module tb_dma_stream_ctrl;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int IN_W   = 64;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'd0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              abort = 1'b0;
  logic              busy, done, err;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic [IN_W-1:0]   din_data = '0;
  logic              dout_valid;
  logic              dout_ready = 1'b0;
  logic [DATA_W-1:0] dout_data;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef DMA_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  dma_stream_ctrl #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .IN_W (IN_W), .LEN_W (LEN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
`ifdef DMA_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Scratchpad model: unwritten words read back as 0xC0DE_0000 | address.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  bit                written [0:(1<<ADDR_W)-1];

  function automatic logic [DATA_W-1:0] mem_peek(input logic [ADDR_W-1:0] a);
    return written[a] ? mem[a] : (32'hC0DE_0000 | {19'd0, a});
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= mem_peek(mem_addr);
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {cmd_ready, busy, done, err, din_ready, dout_valid, mem_en, mem_we}, 8'h80);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_dout"}, dout_data, 0);
`ifdef DMA_STALL_CNT_EN
    check({tag, "_stall"}, stall_cnt, 0);
`endif
  endtask

  // Read-side capture shared by the read scenarios.
  logic [ADDR_W-1:0] rd_addr [16];
  logic [DATA_W-1:0] rd_data [16];
  int nrd, npop, done_cyc, max_out;
  bit [3:0] ready_pat = 4'b1001;  // per-cycle dout_ready 1,0,0,1

  task automatic collect(input int budget, input bit bp);
    nrd = 0; npop = 0; done_cyc = -1; max_out = 0;
    for (int cyc = 0; cyc < budget && done_cyc < 0; cyc++) begin
      dout_ready = bp ? ready_pat[cyc % 4] : 1'b1;
      #1;
      if (mem_en && !mem_we) begin
        if (nrd < 16) rd_addr[nrd] = mem_addr;
        nrd++;
      end
      if (nrd - npop > max_out) max_out = nrd - npop;
      if (dout_valid && dout_ready) begin
        if (npop < 16) rd_data[npop] = dout_data;
        npop++;
      end
      if (done) done_cyc = cyc;
      tick();
    end
    dout_ready = 1'b1;
  endtask

  task automatic write_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit hs;
    issue(2'd1, a, 16'd1);
    din_valid = 1'b1;
    din_data  = {32'hDEAD_BEEF, d};
    done_cyc  = -1;
    for (int cyc = 0; cyc < 10 && done_cyc < 0; cyc++) begin
      #1;
      hs = din_valid && din_ready;
      if (done) done_cyc = cyc;
      tick();
      if (hs) din_valid = 1'b0;
    end
    din_valid = 1'b0;
  endtask

  logic [ADDR_W-1:0] exp_addr [4] = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
  logic [DATA_W-1:0] exp_data [4] = '{32'hC0DE_1FFE, 32'hC0DE_1FFF, 32'hC0DE_0000, 32'hC0DE_0001};
  int k, hs_cnt, nwr;

  initial begin
    // Reset
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // WRITE: 5 words from 3 beats at 0x10
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 13'h10; cmd_len = 16'd5;
    #1 check("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    #1;
    check("wr_busy", busy, 1);
    check("wr_cmd_ready_low", cmd_ready, 0);
    check("wr_din_ready_c1", din_ready, 1);
    k = 0; hs_cnt = 0; nwr = 0; done_cyc = -1;
    for (int cyc = 0; cyc < 20 && done_cyc < 0; cyc++) begin
      din_valid = (k < 3);
      din_data  = {32'(2*k + 2), 32'(2*k + 1)};
      #1;
      if (din_valid && din_ready) begin hs_cnt++; k++; end
      if (mem_en && mem_we) nwr++;
      if (done) done_cyc = cyc;
      tick();
    end
    din_valid = 1'b0;
    #1;
    check("wr_done_one_cycle", done, 0);
    check("wr_back_idle", cmd_ready, 1);
    check("wr_din_hs", hs_cnt, 3);
    check("wr_mem_writes", nwr, 5);
    check("wr_done_cycle", done_cyc, 6);
    for (int i = 0; i < 5; i++) check("wr_mem_word", mem_peek(13'h10 + 13'(i)), 64'(i + 1));
    check("wr_lane_discard", written[13'h15], 0);
    check("wr_err", err, 0);
`ifdef DMA_STALL_CNT_EN
    check("wr_stall_cnt", stall_cnt, 1);
`endif

    // READ across the address wrap
    dout_ready = 1'b1;
    issue(2'd2, 13'h1FFE, 16'd4);
    #1;
    check("rd_first_read", {mem_en, mem_we}, 2'b10);
    check("rd_first_addr", mem_addr, 13'h1FFE);
    check("rd_no_dout_c1", dout_valid, 0);
    collect(30, 1'b0);
    check("rd_nreads", nrd, 4);
    check("rd_npops", npop, 4);
    for (int i = 0; i < 4; i++) begin
      check("rd_addr_order", rd_addr[i], exp_addr[i]);
      check("rd_data", rd_data[i], exp_data[i]);
    end
    check("rd_done_cycle", done_cyc, 5);
`ifdef DMA_STALL_CNT_EN
    check("rd_stall_cnt", stall_cnt, 0);
`endif

    // READ under backpressure
    issue(2'd2, 13'h100, 16'd8);
    collect(60, 1'b1);
    check("bp_nreads", nrd, 8);
    check("bp_npops", npop, 8);
    for (int i = 0; i < 8; i++) check("bp_data", rd_data[i], 32'hC0DE_0100 + 32'(i));
    check("bp_max_buffered_le2", (max_out <= 2), 1);
    check("bp_done_cycle", done_cyc, 17);

    // Illegal op, then legal write clears err
    issue(2'd3, 13'h0, 16'd4);
    #1;
    check("ill_op_err", err, 1);
    check("ill_op_busy", busy, 0);
    check("ill_op_done", done, 0);
    tick();
    #1 check("ill_op_no_done_later", done, 0);
    write_one(13'h20, 32'h0000_00AB);
    #1;
    check("legal_clears_err", err, 0);
    check("w1_done_cycle", done_cyc, 2);
    check("w1_mem", mem_peek(13'h20), 32'h0000_00AB);
    check("w1_upper_lane_dropped", written[13'h21], 0);

    // Zero length, then legal write clears err
    issue(2'd1, 13'h30, 16'd0);
    #1;
    check("len0_err", err, 1);
    check("len0_busy", busy, 0);
    check("len0_done", done, 0);
    write_one(13'h31, 32'h1234_5678);
    #1;
    check("len0_cleared", err, 0);
    check("w2_mem", mem_peek(13'h31), 32'h1234_5678);

    // Abort a READ after three words, then start a new READ at once
    dout_ready = 1'b1;
    issue(2'd2, 13'h200, 16'd8);
    npop = 0;
    for (int cyc = 0; cyc < 12 && npop < 3; cyc++) begin
      #1;
      if (dout_valid && dout_ready) begin
        check("ab_data", dout_data, 32'hC0DE_0200 + 32'(npop));
        npop++;
      end
      tick();
    end
    check("ab_three_words", npop, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #1;
    check("ab_idle", {busy, cmd_ready}, 2'b01);
    check("ab_dout_valid", dout_valid, 0);
    check("ab_no_done", done, 0);
    issue(2'd2, 13'h300, 16'd2);
    #1;
    check("ab_new_busy", busy, 1);
    check("ab_new_addr", mem_addr, 13'h300);
    collect(20, 1'b0);
    check("ab_new_npops", npop, 2);
    check("ab_new_data0", rd_data[0], 32'hC0DE_0300);
    check("ab_new_data1", rd_data[1], 32'hC0DE_0301);
    check("ab_new_done_cycle", done_cyc, 3);

    // Asynchronous reset in the middle of a WRITE
    issue(2'd1, 13'h40, 16'd4);
    din_valid = 1'b1;
    din_data  = {32'd2, 32'd1};
    tick();
    din_valid = 1'b0;
    #1 check("rst_mid_write_active", {mem_en, mem_we, mem_addr}, {2'b11, 13'h40});
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_recover_idle", {cmd_ready, busy, done}, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
